// File: rtl/mips_data_responder.sv
// mips_data_responder
//   Slave end of the CPU data bus: word-addressed RAM plus three MMIO
//   registers (free-running cycle counter, console TX byte push, TX status).
//   Console bytes queue in a small FIFO and drain over a valid/ready stream.
//
// Ports
//   clk             rising-edge clock
//   reset           synchronous, active-low reset (RAM contents survive it)
//   clock_enable    gates CPU-side updates: RAM write, FIFO push, counter, err
//   data_address    byte address from CPU
//   data_read       read strobe; data_readdata is 0 when low
//   data_write      write strobe
//   data_byteenable per-byte write enable, bit i covers writedata[8i+7:8i]
//   data_writedata  write data
//   data_readdata   combinational read data (pre-write value on read+write)
//   tx_valid        console FIFO non-empty
//   tx_data         FIFO head byte
//   tx_ready        consumer accepts head; pop on tx_valid & tx_ready
//   err             sticky illegal-access flag
//
// Memory map
//   0x0 .. (4<<RAM_ADDR_W)-1   RAM
//   0xFFFF0000                 CYCLE      (RO, writes ignored)
//   0xFFFF0004                 TX_DATA    (WO, reads 0)
//   0xFFFF0008                 TX_STATUS  {ovf, err, 12'b0, empty, full, count[15:0]}
//                              write: bit31=1 clears ovf, bit30=1 clears err

module mips_data_responder #(
  parameter     RAM_INIT_FILE = "",
  parameter int RAM_ADDR_W    = 10,
  parameter int FIFO_DEPTH    = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clock_enable,
  input  logic [31:0] data_address,
  input  logic        data_read,
  input  logic        data_write,
  input  logic [3:0]  data_byteenable,
  input  logic [31:0] data_writedata,
  output logic [31:0] data_readdata,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        err
);

  localparam int RAM_WORDS = 1 << RAM_ADDR_W;
  localparam int PTR_W     = $clog2(FIFO_DEPTH);
  localparam int CNT_W     = PTR_W + 1;

  localparam logic [31:0] ADDR_CYCLE  = 32'hFFFF_0000;
  localparam logic [31:0] ADDR_TXDATA = 32'hFFFF_0004;
  localparam logic [31:0] ADDR_STATUS = 32'hFFFF_0008;

  logic [31:0] ram [RAM_WORDS];

  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count;
  logic             ovf;
  logic [31:0]      cycle_cnt;

  // Address decode. The RAM test on the upper bits avoids a wide constant
  // compare that would overflow for large RAM_ADDR_W.
  logic                  aligned, ram_hit, cyc_hit, txd_hit, sts_hit, legal;
  logic [RAM_ADDR_W-1:0] ram_idx;

  assign aligned = (data_address[1:0] == 2'b00);
  assign ram_hit = aligned && ((data_address >> (RAM_ADDR_W + 2)) == 32'd0);
  assign cyc_hit = (data_address == ADDR_CYCLE);
  assign txd_hit = (data_address == ADDR_TXDATA);
  assign sts_hit = (data_address == ADDR_STATUS);
  assign legal   = ram_hit | cyc_hit | txd_hit | sts_hit;
  assign ram_idx = data_address[RAM_ADDR_W+1:2];

  logic full, empty;
  assign full  = (count == CNT_W'(FIFO_DEPTH));
  assign empty = (count == '0);

  logic [31:0] status;
  assign status = {ovf, err, 12'b0, empty, full, 16'(count)};

  // Update qualifiers
  logic ce_wr, push_req, pop, push, ovf_set, sts_wr, err_set;
  assign ce_wr    = clock_enable & data_write;
  assign push_req = ce_wr & txd_hit & data_byteenable[0];
  assign pop      = ~empty & tx_ready;
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign push     = push_req & (~full | pop);
  assign ovf_set  = push_req & full & ~pop;
  assign sts_wr   = ce_wr & sts_hit;
  assign err_set  = clock_enable & ~legal & (data_read | data_write);

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      ovf       <= 1'b0;
      err       <= 1'b0;
      cycle_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
      // Set takes priority over a same-cycle clear so no event is lost.
      ovf <= (ovf & ~(sts_wr & data_writedata[31])) | ovf_set;
      err <= (err & ~(sts_wr & data_writedata[30])) | err_set;
      if (clock_enable) cycle_cnt <= cycle_cnt + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset && push) fifo_mem[wr_ptr] <= data_writedata[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset && ce_wr && ram_hit) begin
      for (int i = 0; i < 4; i++) begin
        if (data_byteenable[i]) ram[ram_idx][8*i +: 8] <= data_writedata[8*i +: 8];
      end
    end
  end

  always_comb begin
    data_readdata = 32'h0;
    if (data_read) begin
      if (ram_hit)      data_readdata = ram[ram_idx];
      else if (cyc_hit) data_readdata = cycle_cnt;
      else if (sts_hit) data_readdata = status;
    end
  end

  assign tx_valid = ~empty;
  assign tx_data  = fifo_mem[rd_ptr];

endmodule

// File: tb/tb_mips_data_responder.sv
module tb_mips_data_responder;

  localparam logic [31:0] A_CYC = 32'hFFFF_0000;
  localparam logic [31:0] A_TXD = 32'hFFFF_0004;
  localparam logic [31:0] A_STS = 32'hFFFF_0008;

  logic        clk = 1'b0;
  logic        reset;
  logic        clock_enable;
  logic [31:0] data_address;
  logic        data_read;
  logic        data_write;
  logic [3:0]  data_byteenable;
  logic [31:0] data_writedata;
  logic [31:0] data_readdata;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        err;

  mips_data_responder #(.RAM_INIT_FILE(""), .RAM_ADDR_W(10), .FIFO_DEPTH(8)) dut (
    .clk(clk), .reset(reset), .clock_enable(clock_enable),
    .data_address(data_address), .data_read(data_read), .data_write(data_write),
    .data_byteenable(data_byteenable), .data_writedata(data_writedata),
    .data_readdata(data_readdata), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .err(err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q [$];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every accepted console byte must match the queue head.
  always @(negedge clk) begin
    if (reset && tx_valid && tx_ready) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL tx_unexpected: got %h expected nothing", tx_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (tx_data !== e) begin
          n_fail++;
          $display("FAIL tx_byte: got %h expected %h", tx_data, e);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    data_address    = a;
    data_writedata  = d;
    data_byteenable = be;
    data_write      = 1'b1;
    cyc();
    data_write      = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string name);
    data_address = a;
    data_read    = 1'b1;
    @(negedge clk);
    check32(name, data_readdata, exp);
    cyc();
    data_read    = 1'b0;
  endtask

  task automatic push_tx(input logic [7:0] b, input bit accepted);
    if (accepted) exp_q.push_back(b);
    wr(A_TXD, {24'h0, b}, 4'b0001);
  endtask

  task automatic drain(input string name);
    bit done;
    done = 1'b0;
    tx_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (!tx_valid) begin
        done = 1'b1;
        break;
      end
      cyc();
    end
    n_tests++;
    if (!done) begin
      n_fail++;
      $display("FAIL %s: got tx_valid=1 after 20 cycles expected 0", name);
    end
    tx_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; clock_enable = 1'b1; data_address = '0; data_read = 1'b0;
    data_write = 1'b0; data_byteenable = '0; data_writedata = '0; tx_ready = 1'b0;
    repeat (3) cyc();
    check32("reset_tx_valid", {31'b0, tx_valid}, 32'd0);
    check32("reset_err", {31'b0, err}, 32'd0);
    reset = 1'b1;
    rd(A_CYC, 32'd0, "reset_cycle");
    rd(A_STS, 32'h0002_0000, "reset_status");

    // 1: byte-enabled RAM writes
    wr(32'h10, 32'hDEADBEEF, 4'b1111);
    wr(32'h10, 32'h0000AA00, 4'b0010);
    rd(32'h10, 32'hDEADAAEF, "ram_byte_merge");
    wr(32'h10, 32'hFFFFFFFF, 4'b0000);
    rd(32'h10, 32'hDEADAAEF, "ram_be_zero");
    data_address = 32'h10; data_writedata = 32'h12345678; data_byteenable = 4'hF;
    data_read = 1'b1; data_write = 1'b1;
    @(negedge clk);
    check32("ram_rw_prewrite", data_readdata, 32'hDEADAAEF);
    cyc();
    data_read = 1'b0; data_write = 1'b0;
    rd(32'h10, 32'h12345678, "ram_rw_landed");
    data_address = 32'h10;
    @(negedge clk);
    check32("read_strobe_low", data_readdata, 32'd0);
    cyc();
    wr(32'hFFC, 32'hCAFEF00D, 4'hF);
    rd(32'hFFC, 32'hCAFEF00D, "ram_top_word");

    // 2: two console bytes, then drain
    tx_ready = 1'b0;
    push_tx(8'h48, 1'b1);
    push_tx(8'h69, 1'b1);
    wr(A_TXD, 32'h0000_5A00, 4'b0010);
    rd(A_STS, 32'h0000_0002, "status_two_queued");
    tx_ready = 1'b1;
    cyc();
    cyc();
    @(negedge clk);
    check32("tx_valid_after_drain", {31'b0, tx_valid}, 32'd0);
    cyc();
    tx_ready = 1'b0;
    rd(A_STS, 32'h0002_0000, "status_empty");

    // 3: overflow
    for (int i = 0; i < 9; i++) push_tx(8'h30 + 8'(i), i < 8);
    rd(A_STS, 32'h8001_0008, "status_overflow");
    wr(A_STS, 32'h8000_0000, 4'hF);
    rd(A_STS, 32'h0001_0008, "status_ovf_cleared");

    // 4: push and pop together while full
    tx_ready = 1'b1;
    push_tx(8'h41, 1'b1);
    tx_ready = 1'b0;
    rd(A_STS, 32'h0001_0008, "full_push_pop_status");
    drain("drain_full");
    rd(A_STS, 32'h0002_0000, "status_after_full_drain");

    // 5: illegal accesses and err
    rd(32'h13, 32'd0, "misaligned_read");
    check32("err_after_misaligned", {31'b0, err}, 32'd1);
    rd(A_STS, 32'h4002_0000, "status_err_set");
    wr(A_STS, 32'h4000_0000, 4'hF);
    rd(A_STS, 32'h0002_0000, "status_err_cleared");
    rd(A_TXD, 32'd0, "txdata_read_zero");
    rd(A_STS, 32'h0002_0000, "txdata_read_legal");
    rd(32'h4000_0000, 32'd0, "unmapped_read");
    rd(32'h1000, 32'd0, "ram_past_end_read");
    rd(A_STS, 32'h4002_0000, "status_err_unmapped");

    // 6: reset mid-drain, then clock_enable freeze
    push_tx(8'h61, 1'b1);
    push_tx(8'h62, 1'b1);
    push_tx(8'h63, 1'b1);
    tx_ready = 1'b1;
    cyc();
    reset = 1'b0;
    cyc();
    exp_q.delete();
    reset = 1'b1;
    clock_enable = 1'b0;
    @(negedge clk);
    check32("tx_valid_after_reset", {31'b0, tx_valid}, 32'd0);
    check32("err_after_reset", {31'b0, err}, 32'd0);
    cyc();
    repeat (4) cyc();
    rd(A_CYC, 32'd0, "cycle_frozen");
    rd(A_STS, 32'h0002_0000, "status_after_reset");
    rd(32'h10, 32'h12345678, "ram_survives_reset");
    clock_enable = 1'b1;
    cyc();
    rd(A_CYC, 32'd1, "cycle_resume");
    tx_ready = 1'b0;

    check32("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
